// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared opcode constants and miss-tracking FSM encodings for the hazard/stall controller.
package hazard_stall_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2,
    ST_BOTH  = 2'd3
  } state_e;

  function automatic logic [6:0] opc_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard check between the load in execute and the consumer in decode.
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  output logic        hazard
);

  logic [6:0] id_opc;
  logic [4:0] ex_rd;
  logic       reads_rs1;
  logic       reads_rs2;

  always_comb begin
    id_opc    = opc_of(id_inst);
    ex_rd     = rd_of(ex_inst);
    // Only fields the decode instruction actually reads may create a dependency.
    reads_rs1 = !(id_opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    reads_rs2 = id_opc inside {OPC_ARI_RTYPE, OPC_STORE, OPC_BRANCH};
    hazard    = (opc_of(ex_inst) == OPC_LOAD) && (ex_rd != 5'd0) &&
                ((reads_rs1 && (rs1_of(id_inst) == ex_rd)) ||
                 (reads_rs2 && (rs2_of(id_inst) == ex_rd)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush controller: cache-miss tracking FSM, deferred redirect flush,
// stall-cycle counter and sticky miss-timeout flag.
//
// state    | meaning
// ST_RUN   | no fill outstanding, pipeline advances
// ST_IMISS | icache fill outstanding
// ST_DMISS | dcache fill outstanding
// ST_BOTH  | both fills outstanding
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_miss,
  input  logic             icache_fill,
  input  logic             dcache_miss,
  input  logic             dcache_fill,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             miss_timeout
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             miss_timeout_q, miss_timeout_d;

  logic hazard;
  logic run;
  logic i_out, d_out, i_nxt, d_nxt;

  load_use_detect u_load_use_detect (
    .id_inst (id_inst),
    .ex_inst (ex_inst),
    .hazard  (hazard)
  );

  always_comb begin
    i_out = (state_q == ST_IMISS) || (state_q == ST_BOTH);
    d_out = (state_q == ST_DMISS) || (state_q == ST_BOTH);
    // Fills only retire an outstanding miss; repeat misses on an outstanding cache are ignored.
    i_nxt = i_out ? !icache_fill : icache_miss;
    d_nxt = d_out ? !dcache_fill : dcache_miss;
    case ({i_nxt, d_nxt})
      2'b10:   state_d = ST_IMISS;
      2'b01:   state_d = ST_DMISS;
      2'b11:   state_d = ST_BOTH;
      default: state_d = ST_RUN;
    endcase

    run    = (state_q == ST_RUN);
    stall  = !run;
    flush  = run && (ex_redirect || flush_pend_q);
    bubble = run && hazard && !flush;

    flush_pend_d = !run && (flush_pend_q || ex_redirect);

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);

    if (run)                    to_cnt_d = '0;
    else if (to_cnt_q == TO_LIM) to_cnt_d = to_cnt_q;
    else                        to_cnt_d = to_cnt_q + TO_W'(1);

    miss_timeout_d = miss_timeout_q || (to_cnt_d == TO_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      flush_pend_q   <= 1'b0;
      stall_count_q  <= '0;
      to_cnt_q       <= '0;
      miss_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_pend_q   <= flush_pend_d;
      stall_count_q  <= stall_count_d;
      to_cnt_q       <= to_cnt_d;
      miss_timeout_q <= miss_timeout_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign miss_timeout = miss_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of outstanding misses, pending flush and counters.
module tb_hazard_stall_ctrl;

  localparam int TB_CNT_W = 6;
  localparam int TB_TO    = 8;
  localparam int TB_TO_W  = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                icache_miss = 1'b0, icache_fill = 1'b0;
  logic                dcache_miss = 1'b0, dcache_fill = 1'b0;
  logic [31:0]         id_inst = NOP, ex_inst = NOP;
  logic                ex_redirect = 1'b0;
  logic                stall, bubble, flush, miss_timeout;
  logic [TB_CNT_W-1:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_ctrl #(.CNT_W(TB_CNT_W), .TIMEOUT(TB_TO), .TO_W(TB_TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_fill(icache_fill),
    .dcache_miss(dcache_miss), .dcache_fill(dcache_fill),
    .id_inst(id_inst), .ex_inst(ex_inst), .ex_redirect(ex_redirect),
    .stall(stall), .bubble(bubble), .flush(flush),
    .stall_count(stall_count), .miss_timeout(miss_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: which caches have a fill outstanding, whether a redirect is waiting,
  // total stalled cycles and length of the current miss episode.
  bit m_i, m_d, m_pend, m_flag, m_st;
  int m_cnt, m_run_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_i = 0; m_d = 0; m_pend = 0; m_flag = 0; m_cnt = 0; m_run_len = 0;
    end else begin
      m_st = m_i || m_d;
      m_pend = m_st && (m_pend || ex_redirect);
      if (m_st) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_run_len < TB_TO) m_run_len++;
        if (m_run_len == TB_TO) m_flag = 1;
      end else begin
        m_run_len = 0;
      end
      if (m_i) m_i = !icache_fill; else m_i = icache_miss;
      if (m_d) m_d = !dcache_fill; else m_d = dcache_miss;
    end
  end

  function automatic bit ref_hazard(input logic [31:0] id, input logic [31:0] ex);
    logic [6:0] io;
    logic [4:0] rd;
    bit r1, r2;
    io = id[6:0];
    rd = ex[11:7];
    r1 = !(io == 7'h37 || io == 7'h17 || io == 7'h6f);
    r2 = (io == 7'h33 || io == 7'h23 || io == 7'h63);
    return (ex[6:0] == 7'h03) && (rd != 0) &&
           ((r1 && id[19:15] == rd) || (r2 && id[24:20] == rd));
  endfunction

  function automatic logic [2:0] ref_ctrl();
    bit s, f, b;
    s = m_i || m_d;
    f = !s && (ex_redirect || m_pend);
    b = !s && !f && ref_hazard(id_inst, ex_inst);
    return {s, b, f};
  endfunction

  function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] lui(input int rd);
    return {20'h12345, 5'(rd), 7'b0110111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    icache_miss = 0; icache_fill = 0; dcache_miss = 0; dcache_fill = 0;
    ex_redirect = 0; id_inst = NOP; ex_inst = NOP;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    n_checks++;
    if ({stall, bubble, flush, miss_timeout} !== 4'b0 || stall_count !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: sbfm=%b count=%0d, want 0000 and 0", {stall, bubble, flush, miss_timeout}, stall_count);
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({stall, bubble, flush} !== 3'b0 || stall_count !== '0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: sbf=%b count=%0d, want 000 and 0", k, {stall, bubble, flush}, stall_count);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ex_tab [6];
    logic [31:0] id_tab [6];
    logic [2:0]  want   [6];
    string       nm     [6];
    ex_tab[0] = lw(5, 1);  id_tab[0] = r_type(6, 5, 7);   want[0] = 3'b010; nm[0] = "lw_add_rs1";
    ex_tab[1] = NOP;       id_tab[1] = r_type(6, 5, 7);   want[1] = 3'b000; nm[1] = "nop_after_bubble";
    ex_tab[2] = lw(0, 1);  id_tab[2] = r_type(6, 0, 7);   want[2] = 3'b000; nm[2] = "rd_x0";
    ex_tab[3] = lw(5, 1);  id_tab[3] = lui(5);            want[3] = 3'b000; nm[3] = "lui_consumer";
    ex_tab[4] = lw(5, 1);  id_tab[4] = sw(5, 2);          want[4] = 3'b010; nm[4] = "store_rs2";
    ex_tab[5] = lw(5, 1);  id_tab[5] = addi(6, 1, 5);     want[5] = 3'b000; nm[5] = "itype_no_rs2";
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ex_inst = ex_tab[k];
      id_inst = id_tab[k];
      @(negedge clk);
      n_checks++;
      if ({stall, bubble, flush} !== want[k]) begin
        n_fail++;
        $display("FAIL load_use_%s: sbf=%b, want %b", nm[k], {stall, bubble, flush}, want[k]);
      end
      tick();
    end
    ex_inst = lw(5, 1); id_inst = r_type(6, 5, 7); ex_redirect = 1;
    @(negedge clk);
    n_checks++;
    if ({stall, bubble, flush} !== 3'b001) begin
      n_fail++;
      $display("FAIL load_use_redirect: sbf=%b, want 001", {stall, bubble, flush});
    end
    tick();
    ex_redirect = 0; ex_inst = NOP; id_inst = NOP;
  endtask

  task automatic test_imiss();
    do_reset();
    icache_miss = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL imiss_pulse_cycle: stall=%b, want 0", stall); end
    tick();
    icache_miss = 0;
    for (int k = 1; k <= 10; k++) begin
      icache_fill = (k == 10);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL imiss_stall[%0d]: stall=%b, want 1", k, stall); end
      tick();
    end
    icache_fill = 0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || stall_count !== 6'd10) begin
      n_fail++;
      $display("FAIL imiss_done: stall=%b count=%0d, want 0 and 10", stall, stall_count);
    end
  endtask

  task automatic test_both();
    do_reset();
    tick();
    for (int k = 0; k <= 8; k++) begin
      dcache_miss = (k == 0);
      icache_miss = (k == 3);
      dcache_fill = (k == 5);
      icache_fill = (k == 7);
      @(negedge clk);
      n_checks++;
      if (stall !== (k >= 1 && k <= 7)) begin
        n_fail++;
        $display("FAIL both_stall[%0d]: stall=%b, want %b", k, stall, (k >= 1 && k <= 7));
      end
      tick();
    end
    {dcache_miss, icache_miss, dcache_fill, icache_fill} = 4'b0;
    n_checks++;
    if (stall_count !== 6'd7) begin n_fail++; $display("FAIL both_count: count=%0d, want 7", stall_count); end
  endtask

  task automatic test_redirect_pend();
    do_reset();
    for (int k = 0; k <= 7; k++) begin
      dcache_miss = (k == 0);
      ex_redirect = (k == 1 || k == 3);
      dcache_fill = (k == 5);
      @(negedge clk);
      n_checks++;
      if ({stall, flush} !== {(k >= 1 && k <= 5), (k == 6)}) begin
        n_fail++;
        $display("FAIL redirect_pend[%0d]: stall,flush=%b%b, want %b%b", k, stall, flush, (k >= 1 && k <= 5), (k == 6));
      end
      tick();
    end
    {dcache_miss, ex_redirect, dcache_fill} = 3'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      icache_miss = (k == 0);
      ex_redirect = (k == 0);
      icache_fill = (k == 3);
      @(negedge clk);
      n_checks++;
      if ({stall, flush} !== {(k >= 1 && k <= 3), (k == 0)}) begin
        n_fail++;
        $display("FAIL simul[%0d]: stall,flush=%b%b, want %b%b", k, stall, flush, (k >= 1 && k <= 3), (k == 0));
      end
      tick();
    end
    {icache_miss, ex_redirect, icache_fill} = 3'b0;
  endtask

  // The flag latches at the edge closing the TIMEOUT-th stall cycle, so it is seen from the next one.
  task automatic test_timeout();
    do_reset();
    icache_miss = 1;
    tick();
    icache_miss = 0;
    for (int k = 1; k <= 13; k++) begin
      icache_fill = (k == 13);
      @(negedge clk);
      n_checks++;
      if (miss_timeout !== (k > TB_TO)) begin
        n_fail++;
        $display("FAIL timeout[%0d]: miss_timeout=%b, want %b", k, miss_timeout, (k > TB_TO));
      end
      tick();
    end
    icache_fill = 0;
    @(negedge clk);
    n_checks++;
    if ({stall, miss_timeout} !== 2'b01 || stall_count !== 6'd13) begin
      n_fail++;
      $display("FAIL timeout_sticky: stall,to=%b%b count=%0d, want 01 and 13", stall, miss_timeout, stall_count);
    end
    tick();
    icache_miss = 1;
    tick();
    icache_miss = 0;
    tick();
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({stall, bubble, flush, miss_timeout} !== 4'b0 || stall_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: sbfm=%b count=%0d, want 0000 and 0", {stall, bubble, flush, miss_timeout}, stall_count);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_run: stall=%b, want 0", stall); end
  endtask

  task automatic test_saturate();
    do_reset();
    dcache_miss = 1;
    tick();
    dcache_miss = 0;
    for (int k = 1; k <= 70; k++) begin
      dcache_fill = (k == 70);
      @(negedge clk);
      if (k == CNT_MAX) begin
        n_checks++;
        if (stall_count !== 6'(CNT_MAX - 1)) begin
          n_fail++;
          $display("FAIL sat_pre: count=%0d, want %0d", stall_count, CNT_MAX - 1);
        end
      end
      tick();
    end
    dcache_fill = 0;
    n_checks++;
    if (stall_count !== 6'(CNT_MAX)) begin
      n_fail++;
      $display("FAIL sat_hold: count=%0d, want %0d", stall_count, CNT_MAX);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] opcs [9];
    opcs[0] = 7'h03; opcs[1] = 7'h23; opcs[2] = 7'h63; opcs[3] = 7'h37; opcs[4] = 7'h17;
    opcs[5] = 7'h6f; opcs[6] = 7'h67; opcs[7] = 7'h33; opcs[8] = 7'h13;
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), opcs[$urandom_range(0, 8)]};
  endfunction

  task automatic test_random();
    logic [2:0] want;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      icache_miss = ($urandom_range(0, 9) == 0);
      dcache_miss = ($urandom_range(0, 9) == 0);
      icache_fill = ($urandom_range(0, 5) == 0);
      dcache_fill = ($urandom_range(0, 5) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      id_inst = rand_inst();
      ex_inst = ($urandom_range(0, 1) == 0) ? lw($urandom_range(0, 3), 1) : rand_inst();
      @(negedge clk);
      want = ref_ctrl();
      n_checks++;
      if ({stall, bubble, flush} !== want) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: sbf=%b, want %b", k, {stall, bubble, flush}, want);
      end
      n_checks++;
      if (stall_count !== 6'(m_cnt) || miss_timeout !== m_flag) begin
        n_fail++;
        $display("FAIL rand_counters[%0d]: count=%0d to=%b, want %0d %b", k, stall_count, miss_timeout, m_cnt, m_flag);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_imiss();
    test_both();
    test_redirect_pend();
    test_simultaneous();
    test_timeout();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer of the pipeline `stall`, `bubble` and `flush` controls; the fetch-side NOP selector consumes them to gate instruction memory versus NOP.
- Sits beside the decode/execute boundary.
- Tracks instruction-cache and data-cache miss handshakes, detects load-use hazards, and defers branch/jump redirects that resolve during a miss stall.
- Keeps a stall-cycle performance counter and a miss-timeout flag.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.
- TIMEOUT, 1024, consecutive miss-stall cycles after which `miss_timeout` sets.
- TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- icache_miss  in  1  pulse: fetch missed; the fill is now outstanding.
- icache_fill  in  1  pulse: the outstanding icache fill completed.
- dcache_miss  in  1  pulse: load/store missed; the fill is now outstanding.
- dcache_fill  in  1  pulse: the outstanding dcache fill completed.
- id_inst  in  32  instruction in decode.
- ex_inst  in  32  instruction in execute.
- ex_redirect  in  1  branch taken or jump resolved in execute this cycle.
- stall  out  1  freeze PC and IF/ID and ID/EX registers.
- bubble  out  1  insert NOP into ID/EX; decode holds.
- flush  out  1  kill IF and ID contents (wrong-path).
- stall_count  out  CNT_W  total cycles with `stall`=1, saturating.
- miss_timeout  out  1  sticky: a miss exceeded TIMEOUT.

Behaviour:
Reset
- Asynchronous on `rst_n`=0.
- FSM state = RUN; flush_pend = 0; all counters = 0; miss_timeout = 0.
- Outputs are combinational from state, so `stall`/`bubble`/`flush` = 0 during reset.
- A reset mid-miss drops all outstanding tracking.

FSM states: RUN, IMISS, DMISS, BOTH.
- RUN:
  - icache_miss & dcache_miss -> BOTH.
  - dcache_miss -> DMISS.
  - icache_miss -> IMISS.
- IMISS:
  - icache_fill -> RUN.
  - dcache_miss (without icache_fill) -> BOTH.
  - dcache_miss & icache_fill -> DMISS.
- DMISS: symmetric to IMISS.
- BOTH:
  - a single fill -> the other single-miss state.
  - both fills -> RUN.
- A fill pulse with no matching outstanding miss is ignored.
- A miss pulse for an already-outstanding cache is ignored.

stall
- stall = (state != RUN). Asserted starting the cycle after the miss pulse.
- The miss pulse cycle itself is covered by the cache holding its own ready low.

Load-use bubble
- Combinational; only evaluated in RUN.
- Condition: ex opcode == LOAD, ex rd != 0, and ex rd equals either:
  - id rs1, for every opcode except LUI/AUIPC/JAL; or
  - id rs2, for R-type, STORE, BRANCH.
- When true: bubble = 1 and stall = 0, exactly one cycle. The next cycle EX holds the NOP, so the condition clears naturally.
- bubble is forced to 0 while stall = 1.

flush
- In RUN, ex_redirect=1 -> flush = 1 the same cycle, and bubble is suppressed.
- If ex_redirect arrives while state != RUN, set flush_pend.
- flush = 1 on the first RUN cycle; flush_pend clears that edge.
- A second redirect while flush_pend is set is merged (single flush).

stall_count
- +1 per cycle with stall = 1. Saturates at all-ones; no wrap.

Timeout
- Counter increments while state != RUN and resets in RUN.
- Reaching TIMEOUT sets `miss_timeout`, which stays set until reset.
- The counter saturates at TIMEOUT.

Simultaneous events
- Miss pulse and redirect in the same RUN cycle: flush = 1 that cycle and the FSM moves to the miss state; no pending flush is recorded.

Decomposition:
- Shared package/header (the existing opcode include): OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_ARI_RTYPE.
- New entries in the same header: FSM state encodings ST_RUN/ST_IMISS/ST_DMISS/ST_BOTH (2 bits).
- One natural sub-module: `load_use_detect`, combinational, taking id_inst and ex_inst and producing the hazard flag.
- The FSM, flush_pend and counters stay in the top module.

Test Plan:
- Reset, then hold rst_n=1 for 5 idle cycles -> stall=bubble=flush=0, stall_count=0.
- ex_inst=LW x5 and id_inst=ADD x6,x5,x7 -> bubble=1 for exactly 1 cycle, stall=0.
  - Repeat with ex rd=x0 -> bubble=0.
  - With id_inst=LUI x5 -> bubble=0.
- icache_miss pulse, icache_fill 10 cycles later -> stall=1 for 10 cycles, stall_count=10, state back to RUN.
- dcache_miss, then icache_miss 3 cycles later, then dcache_fill, then icache_fill -> stall stays 1 throughout; states DMISS->BOTH->IMISS->RUN.
- ex_redirect during DMISS, dcache_fill 4 cycles later -> flush=0 while stalled, flush=1 exactly on the first RUN cycle, then 0.
- TIMEOUT=8; icache_miss with no fill for 12 cycles -> miss_timeout rises on the 8th stall cycle and stays 1 after the fill; rst_n low mid-miss clears everything asynchronously.
